// File: rtl/cpu_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit: next-PC select
// encodings, fetch FSM state codes and the redirect candidate bundle.
package cpu_fetch_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_SRC_W = 3;
    localparam int unsigned STATE_W  = 2;

    // Next-PC select encodings shared with the branch/control logic.
    localparam logic [PC_SRC_W-1:0] PC_SRC_PC_PLUS_4 = 3'd0;
    localparam logic [PC_SRC_W-1:0] PC_SRC_PC_TARGET = 3'd1;
    localparam logic [PC_SRC_W-1:0] PC_SRC_ALU       = 3'd2;
    localparam logic [PC_SRC_W-1:0] PC_SRC_MTVEC     = 3'd3;
    localparam logic [PC_SRC_W-1:0] PC_SRC_MEPC      = 3'd4;

    localparam logic [STATE_W-1:0] FETCH_STATE_FETCH = 2'd0;
    localparam logic [STATE_W-1:0] FETCH_STATE_WAIT  = 2'd1;
    localparam logic [STATE_W-1:0] FETCH_STATE_HOLD  = 2'd2;
    localparam logic [STATE_W-1:0] FETCH_STATE_DRAIN = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] pc_target;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] mtvec;
        logic [XLEN-1:0] mepc;
    } redirect_cand_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(32'h3);
    endfunction

endpackage

// File: rtl/cpu_next_pc.sv
// Combinational redirect decode: selects the redirect target from the branch
// logic candidates and word-aligns register-sourced targets.
module cpu_next_pc
    import cpu_fetch_pkg::*;
(
    input  logic                redirect_valid,
    input  logic [PC_SRC_W-1:0] pc_src,
    input  redirect_cand_t      cand,
    output logic                redirect_c,
    output logic [XLEN-1:0]     target_c
);

    // Unused encodings fall through as "no redirect".
    always_comb begin
        redirect_c = 1'b0;
        target_c   = cand.pc_target;
        if (redirect_valid) begin
            case (pc_src)
                PC_SRC_PC_TARGET: begin
                    redirect_c = 1'b1;
                    target_c   = cand.pc_target;
                end
                PC_SRC_ALU: begin
                    redirect_c = 1'b1;
                    target_c   = word_align(cand.alu_result);
                end
                PC_SRC_MTVEC: begin
                    redirect_c = 1'b1;
                    target_c   = word_align(cand.mtvec);
                end
                PC_SRC_MEPC: begin
                    redirect_c = 1'b1;
                    target_c   = word_align(cand.mepc);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight, buffers
// the fetched word for decode and discards responses of squashed requests.
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [2:0]  pc_src,
    input  logic [31:0] pc_target,
    input  logic [31:0] alu_result,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    req_pc_q, req_pc_d;
    logic [XLEN-1:0]    if_instr_q, if_instr_d;
    logic [XLEN-1:0]    if_pc_q, if_pc_d;

    redirect_cand_t     cand;
    logic               redirect_c;
    logic [XLEN-1:0]    target_c;
    logic               req_hs;

    assign cand = '{pc_target: pc_target, alu_result: alu_result, mtvec: mtvec, mepc: mepc};

    cpu_next_pc u_next_pc (
        .redirect_valid (redirect_valid),
        .pc_src         (pc_src),
        .cand           (cand),
        .redirect_c     (redirect_c),
        .target_c       (target_c)
    );

    // Request port is decoded from state only, so redirects never reach it combinationally.
    assign imem_req_valid = (state_q == FETCH_STATE_FETCH) && !rst;
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign if_valid       = (state_q == FETCH_STATE_HOLD);
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        if (req_hs) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
        end
        if (redirect_c) begin
            pc_d = target_c;
        end

        case (state_q)
            FETCH_STATE_FETCH: begin
                if (req_hs) begin
                    state_d = redirect_c ? FETCH_STATE_DRAIN : FETCH_STATE_WAIT;
                end
            end
            FETCH_STATE_WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect_c) begin
                        state_d = FETCH_STATE_FETCH;
                    end else begin
                        state_d    = FETCH_STATE_HOLD;
                        if_instr_d = imem_resp_data;
                        if_pc_d    = req_pc_q;
                    end
                end else if (redirect_c) begin
                    state_d = FETCH_STATE_DRAIN;
                end
            end
            FETCH_STATE_HOLD: begin
                if (if_ready || redirect_c) begin
                    state_d = FETCH_STATE_FETCH;
                end
            end
            FETCH_STATE_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = FETCH_STATE_FETCH;
                end
            end
            default: state_d = FETCH_STATE_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_STATE_FETCH;
            pc_q       <= RESET_VECTOR;
            req_pc_q   <= '0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed scenarios then random traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_cpu_fetch;
    import cpu_fetch_pkg::*;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [2:0]  pc_src;
    logic [31:0] pc_target, alu_result, mtvec, mepc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;

    cpu_fetch #(.RESET_VECTOR(RV)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .pc_src          (pc_src),
        .pc_target       (pc_target),
        .alu_result      (alu_result),
        .mtvec           (mtvec),
        .mepc            (mepc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: one outstanding read, a squash flag for it, a one-entry buffer.
    bit          m_out, m_sq, m_buf;
    logic [31:0] m_pc, m_req_pc, m_instr, m_ifpc;

    // Stimulus control and memory model state.
    bit          rnd_mode, redir_on_resp;
    int          fix_lat;
    bit          mem_pend;
    int          mem_cnt;
    bit          dut_hs;
    logic [31:0] hs_addr, last_hs_addr;
    int          hs_count, ifv_count;
    logic [31:0] hs_q[$];

    task automatic model_reset();
        m_pc = RV; m_out = 0; m_sq = 0; m_buf = 0;
        m_req_pc = '0; m_instr = '0; m_ifpc = '0;
    endtask

    task automatic model_update();
        bit redir, hs, buf_old, out_old;
        logic [31:0] tgt;
        if (rst) begin
            model_reset();
            return;
        end
        redir = redirect_valid && (pc_src inside {PC_SRC_PC_TARGET, PC_SRC_ALU, PC_SRC_MTVEC, PC_SRC_MEPC});
        case (pc_src)
            PC_SRC_ALU:   tgt = alu_result - (alu_result % 4);
            PC_SRC_MTVEC: tgt = mtvec - (mtvec % 4);
            PC_SRC_MEPC:  tgt = mepc - (mepc % 4);
            default:      tgt = pc_target;
        endcase
        hs      = !m_out && !m_buf && imem_req_ready;
        buf_old = m_buf;
        out_old = m_out;
        if (out_old && imem_resp_valid) begin
            m_out = 0;
            if (!m_sq && !redir) begin
                m_buf = 1; m_instr = imem_resp_data; m_ifpc = m_req_pc;
            end
        end else if (out_old && redir) begin
            m_sq = 1;
        end
        if (buf_old && (if_ready || redir)) m_buf = 0;
        if (hs) begin
            m_out = 1; m_sq = redir; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
        end
        if (redir) m_pc = tgt;
    endtask

    task automatic compare();
        bit exp_rv;
        exp_rv = !rst && !m_out && !m_buf;
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("if_valid", if_valid, m_buf);
        if (m_buf) begin
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", if_pc, m_ifpc);
        end
    endtask

    task automatic drive();
        if (redir_on_resp) redirect_valid = 1'b0;
        if (rnd_mode) begin
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 3) == 0);
            pc_src         = 3'($urandom_range(0, 4));
            pc_target      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            alu_result     = $urandom;
            mtvec          = $urandom;
            mepc           = $urandom;
            if_ready       = 1'($urandom_range(0, 1));
        end
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                mem_pend        = 0;
                if (redir_on_resp) redirect_valid = 1'b1;
            end
        end else if (rnd_mode && !m_out && $urandom_range(0, 15) == 0) begin
            imem_resp_valid = 1'b1;
        end
        imem_req_ready = !mem_pend && (rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
        assert (!(redirect_valid && pc_src > PC_SRC_MEPC))
            else $error("reserved pc_src encoding %0d driven", pc_src);
        #1;
        dut_hs  = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_update();
        if (dut_hs) begin
            mem_pend     = 1;
            mem_cnt      = (fix_lat > 0) ? fix_lat : $urandom_range(1, 4);
            last_hs_addr = hs_addr;
            hs_count++;
            hs_q.push_back(hs_addr);
        end
        #1;
        if (if_valid) ifv_count++;
        compare();
    endtask

    task automatic run_until_hs(input string tag, input int budget);
        int start = hs_count;
        int n = 0;
        while (hs_count == start && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_hs_seen"}, 32'(hs_count != start), 32'd1);
    endtask

    task automatic run_until_ifv(input string tag, input int budget);
        int n = 0;
        while (if_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_ifv_seen"}, 32'(if_valid), 32'd1);
    endtask

    initial begin
        int hs_before, ifv_before;
        rst = 1'b1; redirect_valid = 1'b0; pc_src = PC_SRC_PC_PLUS_4;
        pc_target = '0; alu_result = '0; mtvec = '0; mepc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        if_ready = 1'b1;
        rnd_mode = 0; redir_on_resp = 0; fix_lat = 1;
        mem_pend = 0; mem_cnt = 0; hs_count = 0; ifv_count = 0; last_hs_addr = '0;
        model_reset();

        step();
        step();
        chk("rst_req_valid", imem_req_valid, 32'd0);
        chk("rst_if_valid", if_valid, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        rst = 1'b0;

        // Sequential fetch from the reset vector.
        hs_q.delete();
        repeat (3) run_until_hs("t1", 10);
        chk("t1_req0", hs_q[0], 32'h0000_1000);
        chk("t1_req1", hs_q[1], 32'h0000_1004);
        chk("t1_req2", hs_q[2], 32'h0000_1008);

        // Decode stall holds the buffer and blocks new requests.
        if_ready = 1'b0;
        run_until_ifv("t2", 10);
        hs_before = hs_count;
        repeat (5) step();
        chk("t2_hold_valid", if_valid, 32'd1);
        chk("t2_no_req", hs_count, hs_before);
        if_ready = 1'b1;

        // Redirect while a 3-cycle read is in flight.
        fix_lat = 3;
        run_until_hs("t3a", 10);
        redirect_valid = 1'b1; pc_src = PC_SRC_PC_TARGET; pc_target = 32'h0000_2000;
        ifv_before = ifv_count;
        step();
        redirect_valid = 1'b0;
        run_until_hs("t3b", 10);
        chk("t3_addr", last_hs_addr, 32'h0000_2000);
        chk("t3_discard", ifv_count - ifv_before, 32'd0);

        // ALU redirect while holding a buffered instruction.
        fix_lat = 1; if_ready = 1'b0;
        run_until_ifv("t4", 10);
        redirect_valid = 1'b1; pc_src = PC_SRC_ALU; alu_result = 32'h0000_3001;
        step();
        redirect_valid = 1'b0; if_ready = 1'b1;
        chk("t4_buf_dropped", if_valid, 32'd0);
        run_until_hs("t4", 10);
        chk("t4_addr", last_hs_addr, 32'h0000_3000);

        // MTVEC redirect in the same cycle as the response.
        fix_lat = 2;
        run_until_hs("t5a", 10);
        pc_src = PC_SRC_MTVEC; mtvec = 32'h0000_0080;
        redir_on_resp = 1;
        ifv_before = ifv_count;
        run_until_hs("t5b", 10);
        redir_on_resp = 0; redirect_valid = 1'b0;
        chk("t5_addr", last_hs_addr, 32'h0000_0080);
        chk("t5_no_ifvalid", ifv_count - ifv_before, 32'd0);

        // Reset during DRAIN; the orphan response arrives afterwards.
        fix_lat = 4;
        run_until_hs("t6a", 10);
        redirect_valid = 1'b1; pc_src = PC_SRC_PC_TARGET; pc_target = 32'h0000_4000;
        step();
        redirect_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifv_before = ifv_count;
        run_until_hs("t6b", 12);
        chk("t6_addr", last_hs_addr, RV);
        chk("t6_no_ifvalid", ifv_count - ifv_before, 32'd0);

        // Random traffic.
        rnd_mode = 1; fix_lat = 0;
        repeat (4000) step();
        rnd_mode = 0; rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
